// File: rtl/wb_ctrl_if.sv
// Writeback-port bundle between the execute stage, the memory response path and
// the register file. The DUT takes the slave view; drivers and observers take the master view.
interface wb_ctrl_if;
  logic        exu_valid;
  logic        exu_is_load;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        stall;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        load_err;

  modport slave (
    input  exu_valid, exu_is_load, exu_rd, exu_data,
    input  mem_rsp_valid, mem_rsp_data,
    output stall, reg_we, reg_waddr, reg_wdata,
    output pend_valid, pend_rd, load_err
  );

  modport master (
    output exu_valid, exu_is_load, exu_rd, exu_data,
    output mem_rsp_valid, mem_rsp_data,
    input  stall, reg_we, reg_waddr, reg_wdata,
    input  pend_valid, pend_rd, load_err
  );
endinterface

// File: rtl/wb_ctrl.sv
// Register-file write-port owner: passes ALU results straight through, tracks one
// outstanding load, stalls on port/WAW/second-load conflicts and aborts stale loads.
module wb_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_ctrl_if.slave   bus
);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          pend_valid_q;
  logic [4:0]    pend_rd_q;
  logic          load_err_q;

  logic in_wait;
  logic rsp_hit;
  logic waw_hit;
  logic stall_c;
  logic accept;

  assign in_wait = (state_q == LOAD_WAIT);
  assign rsp_hit = in_wait & bus.mem_rsp_valid;
  assign waw_hit = ~bus.exu_is_load & (bus.exu_rd == pend_rd_q) & (bus.exu_rd != 5'd0);

  // While a load is pending the port is reserved for its response, and only
  // independent non-load results may slip past it.
  assign stall_c = rst_n & in_wait & bus.exu_valid
                 & (bus.mem_rsp_valid | bus.exu_is_load | waw_hit);
  assign accept  = rst_n & bus.exu_valid & ~stall_c;

  always_comb begin
    bus.reg_we    = 1'b0;
    bus.reg_waddr = bus.exu_rd;
    bus.reg_wdata = bus.exu_data;
    if (rsp_hit) begin
      bus.reg_we    = rst_n & (pend_rd_q != 5'd0);
      bus.reg_waddr = pend_rd_q;
      bus.reg_wdata = bus.mem_rsp_data;
    end else if (accept && !bus.exu_is_load) begin
      bus.reg_we    = (bus.exu_rd != 5'd0);
    end
  end

  assign bus.stall      = stall_c;
  assign bus.pend_valid = pend_valid_q;
  assign bus.pend_rd    = pend_rd_q;
  assign bus.load_err   = load_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= 5'd0;
      load_err_q   <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && bus.exu_is_load) begin
            state_q      <= LOAD_WAIT;
            pend_valid_q <= 1'b1;
            pend_rd_q    <= bus.exu_rd;
            timer_q      <= '0;
          end
        end
        LOAD_WAIT: begin
          // A response arriving in the expiry cycle beats the abort.
          if (bus.mem_rsp_valid) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
          end else if (timer_q == TIMER_LAST) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            load_err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          pend_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl with TIMEOUT=4: stimulus pushes expected writes and
// load-error pulses into queues; a negedge monitor pops and compares them.
module tb_wb_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  typedef struct {
    int          c;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  err_q[$];

  wb_ctrl_if bus ();

  wb_ctrl #(.TIMEOUT(4), .TW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
  endtask

  task automatic drv(input logic v, input logic ld, input logic [4:0] rd, input logic [31:0] d,
                     input logic rv, input logic [31:0] rdat);
    bus.exu_valid     = v;
    bus.exu_is_load   = ld;
    bus.exu_rd        = rd;
    bus.exu_data      = d;
    bus.mem_rsp_valid = rv;
    bus.mem_rsp_data  = rdat;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.c = cyc; w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write and every error pulse must match a queued expectation.
  always @(negedge clk) begin
    if (bus.reg_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write cycle=%0d got addr=%0d data=%h expected no write",
                 cyc, bus.reg_waddr, bus.reg_wdata);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("write", {cyc[26:0], bus.reg_waddr, bus.reg_wdata}, {w.c[26:0], w.addr, w.data});
      end
    end
    if (bus.load_err === 1'b1) begin
      if (err_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_load_err cycle=%0d got 1 expected 0", cyc);
      end else begin
        int ec;
        ec = err_q.pop_front();
        check("load_err_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a candidate present to show stall stays low
    drv(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 32'h2);
    #1;
    settle();
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_pend_valid", 64'(bus.pend_valid), 64'd0);
    check("rst_pend_rd", 64'(bus.pend_rd), 64'd0);
    check("rst_load_err", 64'(bus.load_err), 64'd0);
    tick();
    idle();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: reset mid-load discards it
    drv(1'b1, 1'b1, 5'd5, 32'd0, 1'b0, 32'd0);
    settle(); check("t1_issue_stall", 64'(bus.stall), 64'd0); tick();
    idle();
    settle(); check("t1_pend_valid", 64'(bus.pend_valid), 64'd1);
    check("t1_pend_rd", 64'(bus.pend_rd), 64'd5); tick();
    rst_n = 1'b0;
    settle(); check("t1_rst_pend_valid", 64'(bus.pend_valid), 64'd0); tick();
    rst_n = 1'b1;
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'hBAD0BAD0);
    settle(); check("t1_after_pend_valid", 64'(bus.pend_valid), 64'd0); tick();
    idle(); tick();

    // 2: pass-through, x0 suppression, stray response in IDLE
    drv(1'b1, 1'b0, 5'd3, 32'h12345678, 1'b0, 32'd0);
    exp_wr(5'd3, 32'h12345678);
    settle(); check("t2_stall", 64'(bus.stall), 64'd0); tick();
    drv(1'b1, 1'b0, 5'd0, 32'hFFFF0000, 1'b0, 32'd0);
    settle(); check("t2_x0_stall", 64'(bus.stall), 64'd0); tick();
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h55AA55AA);
    settle(); tick();

    // 3: load response collides with an ALU result
    drv(1'b1, 1'b1, 5'd7, 32'd0, 1'b0, 32'd0);
    settle(); tick();
    idle();
    for (int i = 1; i <= 2; i++) begin
      settle(); check("t3_pend_valid", 64'(bus.pend_valid), 64'd1); tick();
    end
    drv(1'b1, 1'b0, 5'd4, 32'h00000044, 1'b1, 32'hDEADBEEF);
    exp_wr(5'd7, 32'hDEADBEEF);
    settle(); check("t3_conflict_stall", 64'(bus.stall), 64'd1); tick();
    drv(1'b1, 1'b0, 5'd4, 32'h00000044, 1'b0, 32'd0);
    exp_wr(5'd4, 32'h00000044);
    settle(); check("t3_retry_stall", 64'(bus.stall), 64'd0);
    check("t3_pend_valid_clr", 64'(bus.pend_valid), 64'd0);
    check("t3_pend_rd_held", 64'(bus.pend_rd), 64'd7); tick();
    idle(); tick();

    // 4a: WAW stall until response
    drv(1'b1, 1'b1, 5'd7, 32'd0, 1'b0, 32'd0);
    settle(); tick();
    drv(1'b1, 1'b0, 5'd7, 32'h77777777, 1'b0, 32'd0);
    for (int i = 1; i <= 2; i++) begin
      settle(); check("t4_waw_stall", 64'(bus.stall), 64'd1); tick();
    end
    drv(1'b1, 1'b0, 5'd7, 32'h77777777, 1'b1, 32'h0BADF00D);
    exp_wr(5'd7, 32'h0BADF00D);
    settle(); check("t4_waw_rsp_stall", 64'(bus.stall), 64'd1); tick();
    drv(1'b1, 1'b0, 5'd7, 32'h77777777, 1'b0, 32'd0);
    exp_wr(5'd7, 32'h77777777);
    settle(); check("t4_waw_go", 64'(bus.stall), 64'd0); tick();

    // 4b: second load stalls; independent ALU passes
    drv(1'b1, 1'b1, 5'd8, 32'd0, 1'b0, 32'd0);
    settle(); tick();
    drv(1'b1, 1'b1, 5'd10, 32'd0, 1'b0, 32'd0);
    settle(); check("t4_load2_stall", 64'(bus.stall), 64'd1); tick();
    drv(1'b1, 1'b1, 5'd10, 32'd0, 1'b1, 32'h88888888);
    exp_wr(5'd8, 32'h88888888);
    settle(); check("t4_load2_rsp_stall", 64'(bus.stall), 64'd1); tick();
    drv(1'b1, 1'b1, 5'd10, 32'd0, 1'b0, 32'd0);
    settle(); check("t4_load2_go", 64'(bus.stall), 64'd0); tick();
    drv(1'b1, 1'b0, 5'd9, 32'h99999999, 1'b0, 32'd0);
    exp_wr(5'd9, 32'h99999999);
    settle(); check("t4_alu9_stall", 64'(bus.stall), 64'd0);
    check("t4_pend_rd10", 64'(bus.pend_rd), 64'd10); tick();
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'hA0A0A0A0);
    exp_wr(5'd10, 32'hA0A0A0A0);
    settle(); tick();
    idle(); tick();

    // 5: timeout abort, late response ignored
    drv(1'b1, 1'b1, 5'd6, 32'd0, 1'b0, 32'd0);
    settle(); tick();
    idle();
    for (int i = 1; i <= 4; i++) begin
      settle(); check("t5_pend_valid", 64'(bus.pend_valid), 64'd1); tick();
    end
    err_q.push_back(cyc);
    settle(); check("t5_abort_pend_valid", 64'(bus.pend_valid), 64'd0); tick();
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h66666666);
    settle(); tick();
    idle(); tick();

    // 6: response in the expiry cycle wins
    drv(1'b1, 1'b1, 5'd11, 32'd0, 1'b0, 32'd0);
    settle(); tick();
    idle();
    for (int i = 1; i <= 3; i++) begin
      settle(); tick();
    end
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'hCAFEF00D);
    exp_wr(5'd11, 32'hCAFEF00D);
    settle(); tick();
    idle();
    settle(); check("t6_pend_valid", 64'(bus.pend_valid), 64'd0); tick();
    repeat (3) tick();

    settle();
    check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    check("err_queue_empty", 64'(err_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
